cmplx_combine: RTL and testbench

Pipelined combine stage of the complex multiplier, directly downstream of the four 8×8 vedic partial-product multipliers. It takes the four 16-bit unsigned products of (a + jb)(c + jd) and produces two 17-bit results:

- real part = ac − bd, in two's complement
- imaginary part = ad + bc, unsigned

Both additions use `csa16` carry-select adders. The block is a two-register valid/ready pipeline at full throughput and keeps a running count of delivered results.

---
 rtl/cmplx_pkg.sv | 8 +
 rtl/cmplx_combine_if.sv | 32 +++
 rtl/csa16.sv | 25 ++
 rtl/cmplx_combine.sv | 99 +++++++++
 tb/tb_cmplx_combine.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmplx_pkg.sv
// Shared widths for the complex-multiplier combine stage.
package cmplx_pkg;

  localparam int PROD_W        = 16;
  localparam int RES_W         = 17;
  localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/cmplx_combine_if.sv
// Product-in / result-out bus of the combine stage, with producer (master) and stage (slave) views.
interface cmplx_combine_if #(
  parameter int CNT_W = cmplx_pkg::CNT_W_DEFAULT
) ();
  import cmplx_pkg::*;

  // Both channels use valid/ready: a beat transfers on a rising edge where
  // valid && ready; the sender holds valid and data stable until that edge,
  // and valid never waits on ready.
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] p_ac;
  logic [PROD_W-1:0] p_bd;
  logic [PROD_W-1:0] p_ad;
  logic [PROD_W-1:0] p_bc;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  re;
  logic [RES_W-1:0]  im;
  logic [CNT_W-1:0]  res_count;

  modport master (
    output in_valid, p_ac, p_bd, p_ad, p_bc, out_ready,
    input  in_ready, out_valid, re, im, res_count
  );

  modport slave (
    input  in_valid, p_ac, p_bd, p_ad, p_bc, out_ready,
    output in_ready, out_valid, re, im, res_count
  );

endinterface

// File: rtl/csa16.sv
// 16-bit carry-select adder: four 4-bit blocks, each precomputing both carry-in cases.
module csa16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [4:0] carry;
  logic [4:0] blk0 [4];
  logic [4:0] blk1 [4];

  assign carry[0] = cin_i;

  for (genvar k = 0; k < 4; k++) begin : g_blk
    assign blk0[k] = {1'b0, a_i[4*k +: 4]} + {1'b0, b_i[4*k +: 4]};
    assign blk1[k] = {1'b0, a_i[4*k +: 4]} + {1'b0, b_i[4*k +: 4]} + 5'd1;
    assign sum_o[4*k +: 4] = carry[k] ? blk1[k][3:0] : blk0[k][3:0];
    assign carry[k+1]      = carry[k] ? blk1[k][4]   : blk0[k][4];
  end

  assign cout_o = carry[4];

endmodule

// File: rtl/cmplx_combine.sv
// Two-register valid/ready combine stage: re = ac - bd (two's complement), im = ad + bc.
module cmplx_combine
  import cmplx_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  cmplx_combine_if.slave bus
);

  logic [PROD_W-1:0] s1_ac_q, s1_bd_q, s1_ad_q, s1_bc_q;
  logic [PROD_W-1:0] s1_ac_d, s1_bd_d, s1_ad_d, s1_bc_d;
  logic              s1_valid_q, s1_valid_d;
  logic              out_valid_q, out_valid_d;
  logic [RES_W-1:0]  re_q, re_d, im_q, im_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              s2_load;
  logic              in_ready;
  logic              accept;

  logic [PROD_W-1:0] bd_inv;
  logic [PROD_W-1:0] sum_r, sum_i;
  logic              cout_r, cout_i;
  logic [RES_W-1:0]  re_next, im_next;

  // Subtraction as ac + ~bd + 1; a clear carry-out is a borrow, i.e. a negative result.
  assign bd_inv = ~s1_bd_q;

  csa16 u_add_re (
    .a_i    (s1_ac_q),
    .b_i    (bd_inv),
    .cin_i  (1'b1),
    .sum_o  (sum_r),
    .cout_o (cout_r)
  );

  csa16 u_add_im (
    .a_i    (s1_ad_q),
    .b_i    (s1_bc_q),
    .cin_i  (1'b0),
    .sum_o  (sum_i),
    .cout_o (cout_i)
  );

  assign re_next = {~cout_r, sum_r};
  assign im_next = {cout_i, sum_i};

  always_comb begin
    s2_load     = s1_valid_q && (!out_valid_q || bus.out_ready);
    in_ready    = !s1_valid_q || s2_load;
    accept      = bus.in_valid && in_ready;

    s1_valid_d  = accept || (s1_valid_q && !s2_load);
    out_valid_d = s1_valid_q || (out_valid_q && !bus.out_ready);

    s1_ac_d = accept ? bus.p_ac : s1_ac_q;
    s1_bd_d = accept ? bus.p_bd : s1_bd_q;
    s1_ad_d = accept ? bus.p_ad : s1_ad_q;
    s1_bc_d = accept ? bus.p_bc : s1_bc_q;

    re_d = s2_load ? re_next : re_q;
    im_d = s2_load ? im_next : im_q;

    cnt_d = (out_valid_q && bus.out_ready) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_ac_q     <= '0;
      s1_bd_q     <= '0;
      s1_ad_q     <= '0;
      s1_bc_q     <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      re_q        <= '0;
      im_q        <= '0;
      cnt_q       <= '0;
    end else begin
      s1_ac_q     <= s1_ac_d;
      s1_bd_q     <= s1_bd_d;
      s1_ad_q     <= s1_ad_d;
      s1_bc_q     <= s1_bc_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      re_q        <= re_d;
      im_q        <= im_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.re        = re_q;
  assign bus.im        = im_q;
  assign bus.res_count = cnt_q;

endmodule

// File: tb/tb_cmplx_combine.sv
// Scoreboard bench for cmplx_combine: inputs sampled into an expected queue, outputs popped and compared.
module tb_cmplx_combine;
  import cmplx_pkg::*;

  localparam int TB_CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cmplx_combine_if #(.CNT_W(TB_CNT_W)) bus ();

  cmplx_combine #(.CNT_W(TB_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [33:0]         exp_q[$];
  logic [33:0]         exp_v;
  logic [TB_CNT_W-1:0] exp_count = '0;
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int cycle = 0;
  int last_pop_cycle = 0;
  int gaps = 0;
  bit first_pop = 1'b1;

  function automatic logic [33:0] model(input logic [15:0] ac, bd, ad, bc);
    logic [16:0] r;
    logic [16:0] i;
    r = {1'b0, ac} - {1'b0, bd};
    i = {1'b0, ad} + {1'b0, bc};
    return {r, i};
  endfunction

  always @(posedge clk) cycle = cycle + 1;

  // Scoreboard: accepted sets are queued, delivered results are popped and compared.
  always @(negedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready)
      exp_q.push_back(model(bus.p_ac, bus.p_bd, bus.p_ad, bus.p_bc));
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got re=%h im=%h, required no result", bus.re, bus.im);
      end else begin
        exp_v = exp_q.pop_front();
        if ({bus.re, bus.im} !== exp_v) begin
          errors++;
          $display("FAIL result: got re=%h im=%h, required re=%h im=%h",
                   bus.re, bus.im, exp_v[33:17], exp_v[16:0]);
        end
      end
      pops++;
      exp_count++;
      if (!first_pop && cycle != last_pop_cycle + 1) gaps++;
      first_pop = 1'b0;
      last_pop_cycle = cycle;
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    exp_q.delete();
    exp_count = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] ac, bd, ad, bc);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.p_ac = ac;
    bus.p_bd = bd;
    bus.p_ad = ad;
    bus.p_bc = bc;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.re, bus.im, bus.res_count} !==
        {1'b0, 1'b1, 17'h0, 17'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_state: got ov=%b ir=%b re=%h im=%h cnt=%h, required ov=0 ir=1 re=0 im=0 cnt=0",
               bus.out_valid, bus.in_ready, bus.re, bus.im, bus.res_count);
    end
    apply_reset();
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    send(16'h1234, 16'h0234, 16'hFFFF, 16'h0001);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_early: got out_valid=%b, required 0", bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.re, bus.im} !== {1'b1, 17'h01000, 17'h10000}) begin
      errors++;
      $display("FAIL basic_result: got ov=%b re=%h im=%h, required ov=1 re=01000 im=10000",
               bus.out_valid, bus.re, bus.im);
    end
    wait_drain(10);
  endtask

  task automatic test_negative();
    bus.out_ready = 1'b1;
    send(16'h0000, 16'h0001, 16'h0000, 16'h0000);
    send(16'h0001, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    checks++;
    if (bus.re !== 17'h1FFFF) begin
      errors++;
      $display("FAIL neg_re: got re=%h, required 1ffff", bus.re);
    end
    @(negedge clk);
    checks++;
    if (bus.re !== 17'h00001) begin
      errors++;
      $display("FAIL pos_re: got re=%h, required 00001", bus.re);
    end
    send(16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.re, bus.im} !== {17'h10001, 17'h1FFFE}) begin
      errors++;
      $display("FAIL boundary_max: got re=%h im=%h, required re=10001 im=1fffe", bus.re, bus.im);
    end
    send(16'hA5A5, 16'hA5A5, 16'h0000, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.re !== 17'h00000) begin
      errors++;
      $display("FAIL equal_products: got re=%h, required 00000", bus.re);
    end
    wait_drain(10);
  endtask

  task automatic test_streaming();
    int p0;
    apply_reset();
    bus.out_ready = 1'b1;
    first_pop = 1'b1;
    gaps = 0;
    p0 = pops;
    for (int i = 0; i < 8; i++)
      send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
           16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    wait_drain(20);
    checks++;
    if (pops - p0 != 8 || gaps != 0) begin
      errors++;
      $display("FAIL stream_delivery: got %0d results with %0d gaps, required 8 with 0 gaps", pops - p0, gaps);
    end
    checks++;
    if (bus.res_count !== 4'd8) begin
      errors++;
      $display("FAIL stream_count: got res_count=%0d, required 8", bus.res_count);
    end
  endtask

  task automatic test_backpressure();
    int p0;
    logic [15:0] a [4];
    apply_reset();
    bus.out_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 4; i++) a[i] = 16'($urandom_range(0, 65535));
    send(a[0], a[1], a[2], a[3]);
    send(a[1], a[0], a[3], a[2]);
    bus.in_valid = 1'b1;
    bus.p_ac = a[2];
    bus.p_bd = a[3];
    bus.p_ad = a[0];
    bus.p_bc = a[1];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.re, bus.im} !== {1'b0, 1'b1, model(a[0], a[1], a[2], a[3])}) begin
        errors++;
        $display("FAIL backpressure_hold: got ir=%b ov=%b re=%h im=%h, required ir=0 ov=1 re=%h im=%h",
                 bus.in_ready, bus.out_valid, bus.re, bus.im,
                 model(a[0], a[1], a[2], a[3]) >> 17, model(a[0], a[1], a[2], a[3]) & 34'h1FFFF);
      end
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(a[2], a[3], a[0], a[1]);
    wait_drain(20);
    checks++;
    if (pops - p0 != 3 || bus.res_count !== 4'd3) begin
      errors++;
      $display("FAIL backpressure_delivery: got %0d results cnt=%0d, required 3 results cnt=3",
               pops - p0, bus.res_count);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    bus.out_ready = 1'b0;
    send(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    send(16'h5555, 16'h6666, 16'h7777, 16'h8888);
    checks++;
    if (bus.res_count !== exp_count) begin
      errors++;
      $display("FAIL count_before_reset: got res_count=%0d, required %0d", bus.res_count, exp_count);
    end
    rst = 1'b1;
    exp_q.delete();
    exp_count = '0;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.re, bus.im, bus.res_count} !==
        {1'b0, 1'b1, 17'h0, 17'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_mid: got ov=%b ir=%b re=%h im=%h cnt=%h, required ov=0 ir=1 re=0 im=0 cnt=0",
               bus.out_valid, bus.in_ready, bus.re, bus.im, bus.res_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    p0 = pops;
    repeat (5) @(negedge clk);
    checks++;
    if (pops != p0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: got %0d results after release, required 0", pops - p0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17; i++)
      send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
           16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    wait_drain(20);
    checks++;
    if (bus.res_count !== 4'd1) begin
      errors++;
      $display("FAIL counter_wrap: got res_count=%0d, required 1", bus.res_count);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.p_ac = '0;
    bus.p_bd = '0;
    bus.p_ad = '0;
    bus.p_bc = '0;
    test_reset();
    test_basic();
    test_negative();
    test_streaming();
    test_backpressure();
    test_reset_mid();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
